// File: rtl/rx_sync_ctrl.sv
// Symbol-lock controller for the RX lane K28.5 detector stage.
// Hunts for evenly spaced COMs, declares/drops lock and forwards non-SKP symbols while locked.
module rx_sync_ctrl #(
  parameter int unsigned MAX_GAP   = 16,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned ERR_LIMIT = 3,
  parameter logic [7:0]  SKP_SYM   = 8'h1C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       k285,
  input  logic       rx_Valid,
  input  logic [7:0] rx_DataS,
  output logic       det_enb,
  output logic       sync_locked,
  output logic       sync_lost,
  output logic [7:0] data_out,
  output logic       data_k,
  output logic       data_valid
);

  localparam int unsigned GAP_W = $clog2(MAX_GAP + 1);
  localparam int unsigned COM_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned ERR_W = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_CHECK  = 2'd2,
    S_LOCKED = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [COM_W-1:0]   com_q, com_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [7:0]         d1_q, d1_d;
  logic               v1_q, v1_d;
  logic               det_enb_q, det_enb_d;
  logic               sync_locked_q, sync_locked_d;
  logic               sync_lost_q, sync_lost_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               data_k_q, data_k_d;
  logic               data_valid_q, data_valid_d;

  logic               timeout;
  logic [COM_W-1:0]   com_inc;
  logic [ERR_W-1:0]   err_inc;
  logic               com_hit;
  logic               err_hit;

  // A coincident k285 always beats the gap limit; WAIT never times out.
  assign timeout = enb && !k285 && (gap_q == GAP_W'(MAX_GAP)) &&
                   ((state_q == S_CHECK) || (state_q == S_LOCKED));
  assign com_inc = com_q + COM_W'(1);
  assign err_inc = err_q + ERR_W'(1);
  assign com_hit = (com_inc == COM_W'(LOCK_CNT));
  assign err_hit = (err_inc == ERR_W'(ERR_LIMIT));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; com_q is zero in WAIT so com_hit also covers LOCK_CNT == 1
  always_comb begin
    state_d = state_q;
    if (enb) begin
      case (state_q)
        S_IDLE:   state_d = S_WAIT;
        S_WAIT:   if (k285) state_d = com_hit ? S_LOCKED : S_CHECK;
        S_CHECK: begin
          if (k285 && com_hit) state_d = S_LOCKED;
          else if (timeout)    state_d = S_WAIT;
        end
        S_LOCKED: if (timeout && err_hit) state_d = S_WAIT;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Counters, input stage and registered outputs
  always_comb begin
    gap_d         = gap_q;
    com_d         = com_q;
    err_d         = err_q;
    d1_d          = d1_q;
    v1_d          = v1_q;
    det_enb_d     = 1'b0;
    sync_lost_d   = 1'b0;
    data_valid_d  = 1'b0;
    sync_locked_d = sync_locked_q;
    data_out_d    = data_out_q;
    data_k_d      = data_k_q;
    if (enb) begin
      d1_d          = rx_DataS;
      v1_d          = rx_Valid;
      data_out_d    = d1_q;
      data_k_d      = v1_q;
      data_valid_d  = (state_q == S_LOCKED) && !(v1_q && (d1_q == SKP_SYM));
      det_enb_d     = (state_d != S_IDLE);
      sync_locked_d = (state_d == S_LOCKED);
      sync_lost_d   = (state_q == S_LOCKED) && (state_d == S_WAIT);

      if (k285 || timeout || (state_q == S_IDLE)) gap_d = '0;
      else                                        gap_d = gap_q + GAP_W'(1);

      case (state_q)
        S_WAIT, S_CHECK: begin
          if (k285)         com_d = com_inc;
          else if (timeout) com_d = '0;
        end
        S_LOCKED: begin
          if (k285) begin
            err_d = '0;
          end else if (timeout) begin
            if (err_hit) begin
              err_d = '0;
              com_d = '0;
            end else begin
              err_d = err_inc;
            end
          end
        end
        default: ;
      endcase

      if ((state_q != S_LOCKED) && (state_d == S_LOCKED)) err_d = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q         <= '0;
      com_q         <= '0;
      err_q         <= '0;
      d1_q          <= 8'h00;
      v1_q          <= 1'b0;
      det_enb_q     <= 1'b0;
      sync_locked_q <= 1'b0;
      sync_lost_q   <= 1'b0;
      data_out_q    <= 8'h00;
      data_k_q      <= 1'b0;
      data_valid_q  <= 1'b0;
    end else begin
      gap_q         <= gap_d;
      com_q         <= com_d;
      err_q         <= err_d;
      d1_q          <= d1_d;
      v1_q          <= v1_d;
      det_enb_q     <= det_enb_d;
      sync_locked_q <= sync_locked_d;
      sync_lost_q   <= sync_lost_d;
      data_out_q    <= data_out_d;
      data_k_q      <= data_k_d;
      data_valid_q  <= data_valid_d;
    end
  end

  assign det_enb     = det_enb_q;
  assign sync_locked = sync_locked_q;
  assign sync_lost   = sync_lost_q;
  assign data_out    = data_out_q;
  assign data_k      = data_k_q;
  assign data_valid  = data_valid_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Bench for rx_sync_ctrl: directed lock/loss scenarios plus random traffic,
// checked every cycle against a counter-based lock model.
module tb_rx_sync_ctrl;

  localparam int MAX_GAP   = 16;
  localparam int LOCK_CNT  = 4;
  localparam int ERR_LIMIT = 3;
  localparam logic [7:0] SKP = 8'h1C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b0;
  logic       k285 = 1'b0;
  logic       rx_Valid = 1'b0;
  logic [7:0] rx_DataS = 8'h00;
  logic       det_enb, sync_locked, sync_lost, data_k, data_valid;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  rx_sync_ctrl #(
    .MAX_GAP(MAX_GAP), .LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .SKP_SYM(SKP)
  ) dut (
    .clk(clk), .rst(rst), .enb(enb), .k285(k285), .rx_Valid(rx_Valid),
    .rx_DataS(rx_DataS), .det_enb(det_enb), .sync_locked(sync_locked),
    .sync_lost(sync_lost), .data_out(data_out), .data_k(data_k),
    .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  // Lock model: count COMs and missed-COM windows, remember the last sampled symbol.
  bit         started = 0;
  bit         locked = 0;
  int         coms = 0;
  int         since = 0;
  int         misses = 0;
  logic [7:0] p_d = 8'h00;
  logic       p_v = 1'b0;
  logic       m_det = 0, m_locked = 0, m_lost = 0, m_k = 0, m_valid = 0;
  logic [7:0] m_dout = 8'h00;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      started = 0; locked = 0; coms = 0; since = 0; misses = 0;
      p_d = 8'h00; p_v = 1'b0;
      m_det = 0; m_locked = 0; m_lost = 0; m_k = 0; m_valid = 0; m_dout = 8'h00;
    end else if (!enb) begin
      m_det = 0; m_valid = 0; m_lost = 0;
    end else begin
      m_dout  = p_d;
      m_k     = p_v;
      m_valid = locked && !(p_v && p_d == SKP);
      m_lost  = 0;
      if (!started) begin
        started = 1;
        since = 0;
      end else if (k285) begin
        since = 0;
        if (locked) misses = 0;
        else begin
          coms++;
          if (coms == LOCK_CNT) begin locked = 1; misses = 0; end
        end
      end else if ((coms > 0 || locked) && since == MAX_GAP) begin
        since = 0;
        if (locked) begin
          misses++;
          if (misses == ERR_LIMIT) begin
            locked = 0; m_lost = 1; coms = 0; misses = 0;
          end
        end else begin
          coms = 0;
        end
      end else begin
        since++;
      end
      m_locked = locked;
      m_det = 1;
      p_d = rx_DataS;
      p_v = rx_Valid;
    end
  end

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    cmp("det_enb", 8'(det_enb), 8'(m_det));
    cmp("sync_locked", 8'(sync_locked), 8'(m_locked));
    cmp("sync_lost", 8'(sync_lost), 8'(m_lost));
    cmp("data_out", data_out, m_dout);
    cmp("data_k", 8'(data_k), 8'(m_k));
    cmp("data_valid", 8'(data_valid), 8'(m_valid));
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_det"}, 8'(det_enb), 8'd0);
    cmp({tag, "_locked"}, 8'(sync_locked), 8'd0);
    cmp({tag, "_lost"}, 8'(sync_lost), 8'd0);
    cmp({tag, "_dout"}, data_out, 8'h00);
    cmp({tag, "_k"}, 8'(data_k), 8'd0);
    cmp({tag, "_valid"}, 8'(data_valid), 8'd0);
  endtask

  function automatic logic [7:0] rnd_sym();
    case ($urandom % 4)
      0:       return SKP;
      1:       return 8'hBC;
      default: return 8'($urandom);
    endcase
  endfunction

  // One cycle: check outputs of the previous edge, then drive inputs for the next.
  task automatic cyc(input logic en, input logic k, input logic v, input logic [7:0] d);
    @(negedge clk);
    compare_all();
    enb = en; k285 = k; rx_Valid = v; rx_DataS = d;
  endtask

  task automatic run_com(input int zeros);
    repeat (zeros) cyc(1'b1, 1'b0, 1'($urandom), rnd_sym());
    cyc(1'b1, 1'b1, 1'b1, 8'hBC);
  endtask

  initial begin
    int cd;
    int gaps[7];
    gaps = '{3, 7, 15, 16, 17, 18, 33};
    cd = 0;

    #1;
    check_zero("reset");
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;

    // COM every 8 cycles, lock on the 4th
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, (i % 8) == 7, 1'b0, 8'h00);
      if (i == 1)  cmp("det_enb_rise", 8'(det_enb), 8'd1);
      if (i == 31) cmp("pre_lock", 8'(sync_locked), 8'd0);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h5A);
    cmp("lock_edge", 8'(sync_locked), 8'd1);
    cmp("model_lock_pin", 8'(m_locked), 8'd1);
    cyc(1'b1, 1'b0, 1'b1, SKP);
    cyc(1'b1, 1'b0, 1'b1, 8'hBC);
    cmp("fwd_5a", data_out, 8'h5A);
    cmp("fwd_5a_k", 8'(data_k), 8'd0);
    cmp("fwd_5a_valid", 8'(data_valid), 8'd1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cmp("skp_strip", 8'(data_valid), 8'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cmp("fwd_bc", data_out, 8'hBC);
    cmp("fwd_bc_k", 8'(data_k), 8'd1);
    cmp("fwd_bc_valid", 8'(data_valid), 8'd1);

    // Stop COMs: loss after three missed windows
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    for (int n = 1; n <= 60; n++) begin
      cyc(1'b1, 1'b0, 1'($urandom), rnd_sym());
      if (n == 51) cmp("still_locked_50", 8'(sync_locked), 8'd1);
      if (n == 52) begin
        cmp("lost_pulse", 8'(sync_lost), 8'd1);
        cmp("unlock", 8'(sync_locked), 8'd0);
        cmp("model_lost_pin", 8'(m_lost), 8'd1);
      end
      if (n == 53) cmp("lost_one_cycle", 8'(sync_lost), 8'd0);
    end

    // Two COMs, 17-cycle gap back to WAIT, then a fresh lock
    run_com(0);
    run_com(7);
    run_com(17);
    run_com(7);
    run_com(7);
    run_com(7);
    cmp("no_early_lock", 8'(sync_locked), 8'd0);
    run_com(7);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cmp("relock", 8'(sync_locked), 8'd1);

    // COMs at the gap boundary, then two timeouts cleared by a COM
    run_com(15);
    run_com(16);
    run_com(16);
    run_com(34);
    run_com(20);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cmp("err_cleared_lock", 8'(sync_locked), 8'd1);

    // Drop lock, freeze mid-CHECK, then resume and lock
    repeat (60) cyc(1'b1, 1'b0, 1'($urandom), rnd_sym());
    run_com(0);
    run_com(7);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int n = 0; n < 20; n++) begin
      cyc(1'b0, 1'($urandom), 1'($urandom), rnd_sym());
      if (n == 2) cmp("frozen_det", 8'(det_enb), 8'd0);
    end
    run_com(2);
    run_com(7);
    cyc(1'b1, 1'b0, 1'b0, 8'h33);
    cmp("lock_after_freeze", 8'(sync_locked), 8'd1);

    // Asynchronous reset while locked
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;

    // Random traffic with COM spacing around the timeout boundary
    for (int n = 0; n < 5000; n++) begin
      logic k;
      if (cd == 0) begin
        k = 1'b1;
        cd = gaps[$urandom % 7];
      end else begin
        k = 1'b0;
        cd--;
      end
      cyc(($urandom % 10) != 0, k, 1'($urandom), rnd_sym());
      if (($urandom % 700) == 0) begin
        @(posedge clk);
        #2 rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_sync_ctrl.md
Name: rx_sync_ctrl

Overview:
- Receive-side symbol-lock controller that sequences the K28.5 detector stage of the RX lane.
- Enables the detector and tracks its k285 strobe.
- Declares lock after a run of correctly spaced COM symbols and drops lock after repeated COM timeouts.
- Forwards decoded symbols downstream only while locked, stripping SKP fillers.

Parameters:
MAX_GAP, 16, maximum enabled cycles allowed between consecutive k285 strobes
LOCK_CNT, 4, consecutive well-spaced COMs required to declare lock
ERR_LIMIT, 3, consecutive COM timeouts while locked that force loss of lock
SKP_SYM, 8'hBC-independent 8'h1C, SKP symbol code to strip from the output stream

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
enb  input  1  global lane enable; low freezes the block
k285  input  1  COM-detected strobe from the detector stage
rx_Valid  input  1  detector flag: 1 = control/K symbol, 0 = data
rx_DataS  input  8  symbol byte from the detector stage
det_enb  output  1  enable driven to the detector stage
sync_locked  output  1  level, lane is symbol-locked
sync_lost  output  1  one-cycle pulse on loss of lock
data_out  output  8  forwarded symbol
data_k  output  1  forwarded symbol is a control symbol
data_valid  output  1  data_out/data_k qualify this cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - det_enb, sync_locked, sync_lost, data_valid, data_k = 0; data_out=8'h00.
  - gap, com_cnt, err_cnt and the input stage = 0.
  - Reset mid-operation aborts immediately, with no sync_lost pulse.
- Input stage: d1<=rx_DataS, v1<=rx_Valid on every enabled edge. This aligns symbols with k285, which lags rx_DataS by one cycle.
- enb=0:
  - All state, counters and the input stage hold.
  - det_enb=0, data_valid=0, sync_lost=0 on the next edge.
  - sync_locked holds its value.
- det_enb is registered: det_enb <= enb && (next state != IDLE).
- gap counter:
  - Width $clog2(MAX_GAP+1); saturates only via the timeout rule.
  - Cleared on k285; incremented on each enabled cycle without k285.
- FSM (all transitions on enabled edges only):
  - IDLE -> WAIT unconditionally on the first enabled edge.
  - WAIT: k285 -> CHECK, com_cnt=1, gap=0. No timeout runs in WAIT.
  - CHECK:
    - k285 -> com_cnt+1, gap=0.
    - If com_cnt+1 == LOCK_CNT -> LOCKED, sync_locked=1 on the same edge, err_cnt=0.
    - No k285 with gap==MAX_GAP -> WAIT, com_cnt=0, gap=0.
  - LOCKED:
    - k285 -> gap=0, err_cnt=0.
    - No k285 with gap==MAX_GAP -> err_cnt+1, gap=0.
    - If err_cnt+1 == ERR_LIMIT -> WAIT, sync_locked=0, sync_lost=1 for exactly one cycle, com_cnt=0, err_cnt=0.
- Simultaneous k285 and gap==MAX_GAP: k285 wins, so no timeout is counted.
- LOCK_CNT=1: the first k285 in WAIT goes directly to LOCKED.
- Output path (registered):
  - data_out<=d1, data_k<=v1.
  - data_valid <= enb && (current state==LOCKED) && !(v1 && d1==SKP_SYM).
  - Latency rx_DataS -> data_out is 2 cycles.
  - The COM that completes lock is not forwarded; forwarding starts on the following cycle.
- data_out and data_k update whenever enb=1 regardless of state; consumers qualify them with data_valid only.

Test Plan:
- Reset then enb=1, k285 pulses every 8 cycles, 4 times -> det_enb=1 one edge after enb; sync_locked rises on the edge sampling the 4th k285; sync_lost stays 0.
- While locked, feed rx_DataS=8'h5A with rx_Valid=0, then 8'h1C with rx_Valid=1, then 8'hBC with rx_Valid=1 -> data_out=5A (data_k=0, data_valid=1) 2 cycles later; SKP cycle has data_valid=0; BC appears with data_k=1, data_valid=1.
- Locked, stop k285 -> after 3×(MAX_GAP+1)=51 enabled cycles sync_locked=0 and sync_lost=1 for one cycle; state WAIT, no further pulses.
- CHECK with 2 COMs, then a gap of 17 cycles -> returns to WAIT; sync_locked never asserts; the next 4 well-spaced COMs lock.
- Locked, k285 arriving exactly when gap==16 -> no error counted; 2 timeouts followed by a k285 reset err_cnt, so a 3rd isolated timeout does not drop lock.
- enb low for 20 cycles mid-CHECK, then rst pulsed low while locked -> counters frozen during enb=0 and lock continues after; async reset clears all outputs immediately, with no sync_lost pulse.
